// File: rtl/pcap_replay_sched_pkg.sv
// Shared types and helpers for the pcap replay scheduler.
package pcap_replay_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HEAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int TS_LSB      = 32;
  localparam int TS_WIDTH    = 32;
  // Widest tuser the strip mask supports; callers truncate to their width.
  localparam int TUSER_MAX_W = 1024;

  // Mask that keeps every tuser bit except the capture timestamp field.
  function automatic logic [TUSER_MAX_W-1:0] ts_strip_mask(input int lsb);
    logic [TUSER_MAX_W-1:0] field;
    field                 = '0;
    field[TS_WIDTH-1:0]   = '1;
    return ~(field << lsb);
  endfunction

endpackage

// File: rtl/pcap_replay_gap_timer.sv
// Inter-packet gap timer: saturating elapsed counter, gap register and a
// registered "gap has elapsed" flag.
//
// elapsed is 0 in the first cycle after an SOP handshake, so the number of
// cycles since that SOP is elapsed+1. The flag asks whether that distance has
// reached the gap, which releases the next SOP exactly gap cycles after the
// previous one. The flag is computed from next-state values so that it is
// current in the same cycle its inputs are.
module pcap_replay_gap_timer
  import pcap_replay_sched_pkg::*;
(
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic                sop_i,
  input  logic                load_i,
  input  logic [TS_WIDTH-1:0] gap_i,
  output logic                gap_met_o
);

  localparam logic [TS_WIDTH-1:0] TS_ONE = {{(TS_WIDTH-1){1'b0}}, 1'b1};

  logic [TS_WIDTH-1:0] elapsed_q, elapsed_d;
  logic [TS_WIDTH-1:0] gap_q, gap_d;
  logic                met_q, met_d;

  // Next-state for counter, gap and the compare flag.
  always_comb begin
    elapsed_d = elapsed_q;
    if (start_i) begin
      elapsed_d = '1;
    end else if (sop_i) begin
      elapsed_d = '0;
    end else if (elapsed_q != '1) begin
      elapsed_d = elapsed_q + TS_ONE;
    end
    gap_d = load_i ? gap_i : gap_q;
    met_d = ({1'b0, elapsed_d} + {{TS_WIDTH{1'b0}}, 1'b1}) >= {1'b0, gap_d};
  end

  // Timer state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      elapsed_q <= '1;
      gap_q     <= '0;
      met_q     <= 1'b1;
    end else begin
      elapsed_q <= elapsed_d;
      gap_q     <= gap_d;
      met_q     <= met_d;
    end
  end

  assign gap_met_o = met_q;

endmodule

// File: rtl/pcap_replay_scheduler.sv
// Timed-release controller for the pcap replay path. Holds each stored packet
// until the gap between consecutive capture timestamps has elapsed, then
// passes it through combinationally.
//
// Handshake: a beat transfers on a cycle where tvalid and tready are both
// high; the output side never drops tvalid or changes data while stalled once
// a packet has started. s_axis_tready and m_axis_tvalid are combinational
// gates of the opposite side, so a beat moves across both ports in the same
// cycle.
module pcap_replay_scheduler #(
  parameter int C_AXIS_DATA_WIDTH  = 512,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int TS_LSB             = 32,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                            axis_aclk,
  input  logic                            axis_reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  input  logic                            ctrl_start,
  input  logic                            ctrl_stop,
  input  logic                            ctrl_timed,
  input  logic [CNT_WIDTH-1:0]            ctrl_pkt_limit,
  output logic [CNT_WIDTH-1:0]            stat_pkt_count,
  output logic                            stat_busy,
  output logic                            stat_done,
  output logic [2:0]                      dbg_state_o
);

  import pcap_replay_sched_pkg::*;

  localparam logic [C_AXIS_TUSER_WIDTH-1:0] TUSER_MASK =
    C_AXIS_TUSER_WIDTH'(ts_strip_mask(TS_LSB));
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic                   timed_q;
  logic                   first_q;
  logic                   stop_pending_q;
  logic [CNT_WIDTH-1:0]   limit_q;
  logic [CNT_WIDTH-1:0]   pkt_count_q;
  logic [TS_WIDTH-1:0]    prev_ts_q;

  logic [TS_WIDTH-1:0]    hdr_ts;
  logic [TS_WIDTH-1:0]    gap_calc;
  logic                   gap_met;
  logic                   pass;
  logic                   s_ready;
  logic                   m_valid;
  logic                   beat_hs;
  logic                   sop_hs;
  logic                   eop_hs;
  logic                   idle_like;
  logic                   start_acc;
  logic                   head_load;
  logic                   limit_hit;
  logic                   end_run;

  assign hdr_ts    = s_axis_tuser[TS_LSB +: TS_WIDTH];
  // Modular subtraction handles timestamp wrap; the first packet after a
  // start and untimed mode are never delayed.
  assign gap_calc  = (first_q || !timed_q) ? '0 : (hdr_ts - prev_ts_q);

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign start_acc = idle_like && ctrl_start && !ctrl_stop;
  assign head_load = (state_q == ST_HEAD) && s_axis_tvalid && !ctrl_stop;
  assign beat_hs   = s_axis_tvalid && s_ready;
  assign sop_hs    = beat_hs && (state_q == ST_WAIT);
  assign eop_hs    = beat_hs && s_axis_tlast;
  assign limit_hit = (limit_q != '0) && ((pkt_count_q + CNT_ONE) == limit_q);
  assign end_run   = stop_pending_q || ctrl_stop || limit_hit;

  pcap_replay_gap_timer u_gap_timer (
    .clk_i     (axis_aclk),
    .reset_i   (axis_reset),
    .start_i   (start_acc),
    .sop_i     (sop_hs),
    .load_i    (head_load),
    .gap_i     (gap_calc),
    .gap_met_o (gap_met)
  );

  // FSM state register.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a stop pulse beats a same-cycle start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_acc) state_d = ST_HEAD;
      end
      ST_HEAD: begin
        if (ctrl_stop)          state_d = ST_DONE;
        else if (s_axis_tvalid) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ctrl_stop) begin
          state_d = ST_DONE;
        end else if (sop_hs) begin
          if (eop_hs) state_d = end_run ? ST_DONE : ST_HEAD;
          else        state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (eop_hs) state_d = end_run ? ST_DONE : ST_HEAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: stream gating; a stop in WAIT blocks the SOP beat.
  always_comb begin
    pass    = 1'b0;
    s_ready = 1'b0;
    m_valid = 1'b0;
    unique case (state_q)
      ST_WAIT: begin
        pass = 1'b1;
        if (gap_met && !ctrl_stop) begin
          m_valid = s_axis_tvalid;
          s_ready = m_axis_tready;
        end
      end
      ST_SEND: begin
        pass    = 1'b1;
        m_valid = s_axis_tvalid;
        s_ready = m_axis_tready;
      end
      default: begin
        pass    = 1'b0;
      end
    endcase
  end

  // Replay control registers, packet counter and timestamp history.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      timed_q        <= 1'b0;
      limit_q        <= '0;
      pkt_count_q    <= '0;
      first_q        <= 1'b1;
      stop_pending_q <= 1'b0;
      prev_ts_q      <= '0;
    end else begin
      if (start_acc) begin
        timed_q        <= ctrl_timed;
        limit_q        <= ctrl_pkt_limit;
        pkt_count_q    <= '0;
        first_q        <= 1'b1;
        stop_pending_q <= 1'b0;
      end else begin
        if (eop_hs)                               pkt_count_q    <= pkt_count_q + CNT_ONE;
        if (sop_hs)                               first_q        <= 1'b0;
        if ((state_q == ST_SEND) && ctrl_stop)    stop_pending_q <= 1'b1;
      end
      if (head_load) prev_ts_q <= hdr_ts;
    end
  end

  assign s_axis_tready  = s_ready;
  assign m_axis_tvalid  = m_valid;
  assign m_axis_tdata   = pass ? s_axis_tdata : '0;
  assign m_axis_tkeep   = pass ? s_axis_tkeep : '0;
  assign m_axis_tlast   = pass && s_axis_tlast;
  assign m_axis_tuser   = pass ? (s_axis_tuser & TUSER_MASK) : '0;
  assign stat_pkt_count = pkt_count_q;
  assign stat_busy      = (state_q == ST_HEAD) || (state_q == ST_WAIT) || (state_q == ST_SEND);
  assign stat_done      = (state_q == ST_DONE);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_pcap_replay_scheduler.sv
// Bench for pcap_replay_scheduler: table of replay scenarios plus hand-written
// stop, backpressure and reset sequences.
module tb_pcap_replay_scheduler;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int UW = 128;
  localparam int CW = 32;
  localparam int BW = 257;  // {last, keep[63:0], user[127:0], tag[63:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic axis_reset = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic [UW-1:0] s_tuser = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b1;
  logic          ctrl_start = 1'b0;
  logic          ctrl_stop = 1'b0;
  logic          ctrl_timed = 1'b0;
  logic [CW-1:0] ctrl_pkt_limit = '0;
  logic [CW-1:0] stat_pkt_count;
  logic          stat_busy;
  logic          stat_done;
  logic [2:0]    dbg_state;

  pcap_replay_scheduler dut (
    .axis_aclk      (clk),
    .axis_reset     (axis_reset),
    .s_axis_tdata   (s_tdata),
    .s_axis_tkeep   (s_tkeep),
    .s_axis_tuser   (s_tuser),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tlast   (s_tlast),
    .s_axis_tready  (s_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tuser   (m_tuser),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tlast   (m_tlast),
    .m_axis_tready  (m_tready),
    .ctrl_start     (ctrl_start),
    .ctrl_stop      (ctrl_stop),
    .ctrl_timed     (ctrl_timed),
    .ctrl_pkt_limit (ctrl_pkt_limit),
    .stat_pkt_count (stat_pkt_count),
    .stat_busy      (stat_busy),
    .stat_done      (stat_done),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [BW-1:0] src_q[$];
  logic [BW-1:0] exp_q[$];
  int            sop_q[$];
  int            out_beats = 0;
  int            pkt_id = 0;
  int            start_cyc = 0;
  logic          bp_en = 1'b0;
  logic          src_fire = 1'b0;
  logic          mid = 1'b0;
  logic          prev_stall = 1'b0;
  logic [63:0]   prev_tag = '0;
  logic [BW-1:0] src_w;
  logic [BW-1:0] mon_e;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Upstream source: presents the head of src_q, pops on handshake, and
  // drives the downstream ready (optionally random at 30% stall).
  always @(posedge clk) begin
    #1;
    if (axis_reset) src_q.delete();
    else if (src_fire && src_q.size() > 0) src_q.delete(0);
    if (src_q.size() > 0) begin
      src_w    = src_q[0];
      s_tvalid = 1'b1;
      s_tdata  = {8{src_w[63:0]}};
      s_tuser  = src_w[191:64];
      s_tkeep  = src_w[255:192];
      s_tlast  = src_w[256];
    end else begin
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tuser  = '0;
      s_tkeep  = '0;
      s_tlast  = 1'b0;
    end
    m_tready = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
  end

  // Output monitor: stall stability, SOP timestamps and data scoreboard.
  always @(negedge clk) begin
    src_fire = s_tvalid & s_tready;
    if (axis_reset) begin
      mid        = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", m_tvalid, 1);
        check("stall_data", m_tdata[63:0], prev_tag);
      end
      if (m_tvalid && m_tready) begin
        if (!mid) sop_q.push_back(cyc);
        mid = !m_tlast;
        out_beats++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_beat: got tdata 0x%0h, want no beat (cycle %0d)", m_tdata[63:0], cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("tdata_lo", m_tdata[63:0], mon_e[63:0]);
          check("tdata_hi", m_tdata[DW-1 -: 64], mon_e[63:0]);
          check("tuser", m_tuser, mon_e[191:64]);
          check("tuser_ts", m_tuser[32 +: 32], 0);
          check("tkeep", m_tkeep, mon_e[255:192]);
          check("tlast", m_tlast, mon_e[256]);
        end
      end
      prev_stall = m_tvalid & ~m_tready;
      prev_tag   = m_tdata[63:0];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_pkt(input int nbeats, input logic [31:0] ts);
    logic [BW-1:0]  w;
    logic [63:0]    tag;
    logic [63:0]    keep;
    logic [127:0]   user;
    logic           last;
    for (int b = 0; b < nbeats; b++) begin
      last = (b == nbeats - 1);
      tag  = {16'(pkt_id), 16'(b), 32'($urandom)};
      keep = last ? 64'h0000_0000_FFFF_FFFF : {64{1'b1}};
      user = {64'hFEED_FACE_0BAD_BEEF, ts, 32'(pkt_id)};
      w    = {last, keep, user, tag};
      src_q.push_back(w);
      user[63:32] = '0;
      exp_q.push_back({last, keep, user, tag});
    end
    pkt_id++;
  endtask

  task automatic flush();
    src_q.delete();
    exp_q.delete();
    sop_q.delete();
  endtask

  task automatic pulse_start(input logic timed, input int limit);
    @(posedge clk); #2;
    ctrl_start     = 1'b1;
    ctrl_timed     = timed;
    ctrl_pkt_limit = CW'(limit);
    start_cyc      = cyc;
    @(posedge clk); #2;
    ctrl_start     = 1'b0;
    @(negedge clk); #1;
    check("busy_after_start", stat_busy, 1);
  endtask

  task automatic pulse_stop();
    @(posedge clk); #2;
    ctrl_stop = 1'b1;
    @(posedge clk); #2;
    ctrl_stop = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (!stat_done && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    check("done_reached", stat_done, 1);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int i;
    i = 0;
    while (out_beats < target && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    check("beats_reached", out_beats >= target, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        timed;
    int          limit;
    int          nbeats;
    int          npkts;
    int          extra;
    logic [31:0] ts0;
    logic [31:0] ts1;
    logic [31:0] ts2;
    int          sp1;
    int          sp2;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] ts;
    @(posedge clk); #2;
    flush();
    for (int k = 0; k < v.npkts + v.extra; k++) begin
      ts = (k == 0) ? v.ts0 : (k == 1) ? v.ts1 : (k == 2) ? v.ts2 : v.ts2 + 32'd1000;
      push_pkt(v.nbeats, ts);
    end
    pulse_start(v.timed, v.limit);
    wait_done(400);
    repeat (5) @(negedge clk);
    #1;
    check($sformatf("v%0d_sop_count", idx), sop_q.size(), v.npkts);
    if (sop_q.size() >= 1) check($sformatf("v%0d_first_lat", idx), sop_q[0] - start_cyc, 2);
    if (sop_q.size() >= 2) check($sformatf("v%0d_spacing1", idx), sop_q[1] - sop_q[0], v.sp1);
    if (sop_q.size() >= 3 && v.npkts >= 3)
      check($sformatf("v%0d_spacing2", idx), sop_q[2] - sop_q[1], v.sp2);
    check($sformatf("v%0d_pkt_count", idx), stat_pkt_count, v.limit);
    check($sformatf("v%0d_busy", idx), stat_busy, 0);
    check($sformatf("v%0d_left_beats", idx), src_q.size(), v.extra * v.nbeats);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base;
    int sp;

    vecs[0] = '{1'b0, 3, 2, 3, 1, 32'd0,          32'd0,          32'd0,  3,  3};
    vecs[1] = '{1'b1, 3, 1, 3, 0, 32'd100,        32'd150,        32'd160, 50, 10};
    vecs[2] = '{1'b1, 2, 1, 2, 0, 32'hFFFF_FFF0,  32'h0000_0010,  32'd0,  32, 0};
    vecs[3] = '{1'b1, 2, 4, 2, 0, 32'd1000,       32'd1002,       32'd0,  5,  0};
    vecs[4] = '{1'b0, 2, 1, 2, 0, 32'd500,        32'd100,        32'd0,  2,  0};
    vecs[5] = '{1'b1, 3, 3, 3, 0, 32'd7,          32'd7,          32'd27, 4,  20};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tdata", m_tdata[63:0], 0);
    check("rst_m_tuser", m_tuser, 0);
    check("rst_count", stat_pkt_count, 0);
    check("rst_busy", stat_busy, 0);
    check("rst_done", stat_done, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #2;
    axis_reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Stop during SEND of a 4-beat packet: whole packet goes out, then DONE.
    @(posedge clk); #2;
    flush();
    push_pkt(4, 32'd0);
    push_pkt(1, 32'd0);
    base = out_beats;
    pulse_start(1'b0, 0);
    wait_beats(base + 2, 50);
    pulse_stop();
    wait_done(50);
    repeat (3) @(negedge clk);
    #1;
    check("stop_send_beats", out_beats - base, 4);
    check("stop_send_count", stat_pkt_count, 1);
    check("stop_send_left", src_q.size(), 1);

    // Stop while waiting on a long gap: DONE next cycle, no beat consumed.
    @(posedge clk); #2;
    flush();
    push_pkt(1, 32'd0);
    push_pkt(1, 32'd1000);
    pulse_start(1'b1, 0);
    wait_beats(out_beats + 1, 20);
    repeat (5) @(negedge clk);
    pulse_stop();
    @(negedge clk); #1;
    check("stop_wait_done", stat_done, 1);
    check("stop_wait_count", stat_pkt_count, 1);
    check("stop_wait_left", src_q.size(), 1);
    check("stop_wait_sops", sop_q.size(), 1);

    // Timed gap of 20 under random downstream backpressure.
    @(posedge clk); #2;
    flush();
    bp_en = 1'b1;
    push_pkt(3, 32'd40);
    push_pkt(3, 32'd60);
    pulse_start(1'b1, 2);
    wait_done(300);
    repeat (3) @(negedge clk);
    #1;
    check("bp_sop_count", sop_q.size(), 2);
    if (sop_q.size() >= 2) begin
      sp = sop_q[1] - sop_q[0];
      check("bp_gap_not_early", sp >= 20, 1);
    end
    check("bp_count", stat_pkt_count, 2);
    check("bp_exp_empty", exp_q.size(), 0);
    bp_en = 1'b0;

    // Reset in the middle of a packet, then start+stop together.
    @(posedge clk); #2;
    flush();
    push_pkt(4, 32'd0);
    base = out_beats;
    pulse_start(1'b0, 0);
    wait_beats(base + 2, 50);
    @(posedge clk); #2;
    axis_reset = 1'b1;
    @(posedge clk); #2;
    axis_reset = 1'b0;
    flush();
    @(negedge clk); #1;
    check("mid_rst_m_tvalid", m_tvalid, 0);
    check("mid_rst_m_tlast", m_tlast, 0);
    check("mid_rst_m_tdata", m_tdata[63:0], 0);
    check("mid_rst_m_tkeep", m_tkeep, 0);
    check("mid_rst_s_tready", s_tready, 0);
    check("mid_rst_count", stat_pkt_count, 0);
    check("mid_rst_state", dbg_state, 0);
    @(posedge clk); #2;
    ctrl_start = 1'b1;
    ctrl_stop  = 1'b1;
    @(posedge clk); #2;
    ctrl_start = 1'b0;
    ctrl_stop  = 1'b0;
    @(negedge clk); #1;
    check("start_stop_state", dbg_state, 0);
    check("start_stop_busy", stat_busy, 0);
    check("start_stop_done", stat_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
